// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// ----------------
// Arbitrates the single-port 256-byte data memory between the CPU load/store
// unit (port 0) and the debug/loader port (port 1). Every access runs through
// three states:
//   IDLE   -> pick a winner
//   ACCESS -> drive the memory for one cycle
//   DONE   -> pulse the ack (and fault, if the write was blocked)
// Writes whose start address lies in [RO_LO, RO_HI] are blocked. They still
// occupy an ACCESS cycle, but with both enables low.
//
// Configuration macro: DATA_MEM_ARB_RR_EN
//   defined   -> round-robin on a tie (the port not granted last wins;
//                last_grant resets to 1, so port 0 wins the first tie)
//   undefined -> fixed priority, port 1 always wins a tie (no last_grant state)
//
// Handshake: a requester raises mX_req with mX_we/mX_addr/mX_wdata stable and
// holds it until mX_ack (a one-cycle pulse in DONE). A req still high in the
// following IDLE cycle is a new transaction. Nothing is queued: requests are
// re-sampled in every IDLE cycle.
//
// Ports:
//   CLK, RST_N              clock (rising edge), async active-low reset
//   m0_*/m1_*               requester ports: req/we/addr/wdata in,
//                           ack/rdata/fault out
//   debug_mode              1 = port 0 requests are not eligible
//   mem_address/mem_wdata   memory address and write data (registered)
//   mem_read_en/mem_write_en  memory enables (registered, mutually exclusive)
//   mem_rdata               combinational read data from the memory
//   dbg_state               current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module data_mem_arbiter #(
  parameter logic [7:0] RO_LO = 8'h4D,
  parameter logic [7:0] RO_HI = 8'h51
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [7:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [7:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  output logic        m0_fault,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        m1_fault,
  input  logic        debug_mode,
  output logic [7:0]  mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;      // 0 = port 0, 1 = port 1
  logic        we_q, we_d;
  logic        blocked_q, blocked_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        fault0_q, fault0_d, fault1_q, fault1_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        elig0, elig1, pick1;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_blocked;

  // debug_mode only gates new grants; an access already granted to port 0
  // runs to completion.
  assign elig0 = m0_req & ~debug_mode;
  assign elig1 = m1_req;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  // On a tie, the port that was not granted last wins.
  assign pick1 = elig1 & (~elig0 | ~last_grant_q);
`else
  // Fixed priority: the debug port wins every tie.
  assign pick1 = elig1;
`endif

  assign sel_we      = pick1 ? m1_we    : m0_we;
  assign sel_addr    = pick1 ? m1_addr  : m0_addr;
  assign sel_wdata   = pick1 ? m1_wdata : m0_wdata;
  assign sel_blocked = sel_we && (sel_addr >= RO_LO) && (sel_addr <= RO_HI);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    blocked_d = blocked_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    fault0_d  = 1'b0;
    fault1_d  = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
`ifdef DATA_MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          grant_d   = pick1;
          we_d      = sel_we;
          blocked_d = sel_blocked;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          rd_en_d   = ~sel_we;
          wr_en_d   = sel_we & ~sel_blocked;
          state_d   = S_ACCESS;
`ifdef DATA_MEM_ARB_RR_EN
          last_grant_d = pick1;
`endif
        end
      end
      S_ACCESS: begin
        // The memory is combinational, so its read data is valid by the end
        // of the ACCESS cycle and can be captured on the edge entering DONE.
        state_d  = S_DONE;
        ack0_d   = ~grant_q;
        ack1_d   = grant_q;
        fault0_d = ~grant_q & blocked_q;
        fault1_d = grant_q & blocked_q;
        if (!we_q) begin
          if (grant_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      blocked_q <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 16'h0000;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      fault0_q  <= 1'b0;
      fault1_q  <= 1'b0;
      rdata0_q  <= 16'h0000;
      rdata1_q  <= 16'h0000;
`ifdef DATA_MEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      blocked_q <= blocked_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      fault0_q  <= fault0_d;
      fault1_q  <= fault1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef DATA_MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m0_ack       = ack0_q;
  assign m1_ack       = ack1_q;
  assign m0_fault     = fault0_q;
  assign m1_fault     = fault1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter.
// A transaction-level reference model predicts every output on every cycle:
// - a granted transaction is held in exp_q;
// - the model counts how many cycles remain until the arbiter is free again;
// - expected read data comes from the bench's own memory image.
// Directed sequences follow the test plan; a random phase then exercises
// mixed traffic with random debug_mode.
module tb_data_mem_arbiter;

  localparam logic [7:0] RO_LO = 8'h4D;
  localparam logic [7:0] RO_HI = 8'h51;

  // ---------------- clock / reset / signals ----------------
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, debug_mode = 0;
  logic [7:0]  m0_addr = 0, m1_addr = 0;
  logic [15:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, m0_fault, m1_fault;
  logic [15:0] m0_rdata, m1_rdata;
  logic [7:0]  mem_address;
  logic        mem_read_en, mem_write_en;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [15:0] mem_img [256];

  always #5 CLK = ~CLK;

  assign mem_rdata = mem_img[mem_address];

  data_mem_arbiter #(.RO_LO(RO_LO), .RO_HI(RO_HI)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .debug_mode(debug_mode),
    .mem_address(mem_address), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q entry: {we, port, addr[7:0], wdata[15:0]}
  logic [25:0] exp_q[$];
  int          busy;        // 2: access cycle, 1: ack cycle, 0: free
  bit          last_port;   // port granted most recently
  logic [15:0] exp_rd0, exp_rd1;

  function automatic bit is_blocked(input bit we, input logic [7:0] a);
    return we && (a >= RO_LO) && (a <= RO_HI);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    busy      = 0;
    last_port = 1'b1;
    exp_rd0   = 16'h0;
    exp_rd1   = 16'h0;
  endtask

  // Called right after each rising edge with the inputs that edge saw.
  task automatic model_edge();
    logic [25:0] t;
    bit e0, e1, w;
    if (!RST_N) begin
      model_reset();
      return;
    end
    if (busy == 2) begin
      busy = 1;
      t = exp_q[0];
      if (!t[25]) begin
        if (t[24]) exp_rd1 = mem_img[t[23:16]];
        else       exp_rd0 = mem_img[t[23:16]];
      end
    end else if (busy == 1) begin
      busy = 0;
      void'(exp_q.pop_front());
    end else begin
      e0 = m0_req && !debug_mode;
      e1 = m1_req;
      if (e0 || e1) begin
        if (e0 && e1) begin
`ifdef DATA_MEM_ARB_RR_EN
          w = ~last_port;
`else
          w = 1'b1;
`endif
        end else begin
          w = e1;
        end
        last_port = w;
        if (w) exp_q.push_back({m1_we, 1'b1, m1_addr, m1_wdata});
        else   exp_q.push_back({m0_we, 1'b0, m0_addr, m0_wdata});
        busy = 2;
      end
    end
  endtask

  task automatic check_outputs();
    logic [25:0] t;
    bit acc, dn, blk;
    t   = (exp_q.size() > 0) ? exp_q[0] : 26'h0;
    acc = (busy == 2);
    dn  = (busy == 1);
    blk = is_blocked(t[25], t[23:16]);
    check_eq("mem_read_en", mem_read_en, acc && !t[25]);
    check_eq("mem_write_en", mem_write_en, acc && t[25] && !blk);
    if (acc) check_eq("mem_address", mem_address, t[23:16]);
    if (acc && t[25] && !blk) check_eq("mem_wdata", mem_wdata, t[15:0]);
    check_eq("m0_ack", m0_ack, dn && !t[24]);
    check_eq("m1_ack", m1_ack, dn && t[24]);
    check_eq("m0_fault", m0_fault, dn && !t[24] && blk);
    check_eq("m1_fault", m1_fault, dn && t[24] && blk);
    check_eq("m0_rdata", m0_rdata, exp_rd0);
    check_eq("m1_rdata", m1_rdata, exp_rd1);
  endtask

  // One clock: model follows the rising edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input bit we, input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) m0_req = 0;
    else        m1_req = 0;
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 8'h4C;
      1: return 8'h4D;
      2: return 8'h4E;
      3: return 8'h51;
      4: return 8'h52;
      5: return 8'hFF;
      6: return 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Ticks until port p acks, up to max cycles; n = cycles taken or -1.
  task automatic wait_ack(input int p, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((p == 0 && m0_ack) || (p == 1 && m1_ack)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    RST_N = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) tick();
    RST_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, a0, a1, first_p, last_cyc, gap_bad;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    model_reset();

    // Reset: every output is 0.
    apply_reset(3);
    check_eq("rst_mem_address", mem_address, 8'h0);
    check_eq("rst_mem_wdata", mem_wdata, 16'h0);
    check_eq("rst_dbg_state", dbg_state, 2'd0);

    // Both ports reading continuously for 12 cycles.
    drive_req(0, 0, 8'h40, 16'h0);
    drive_req(1, 0, 8'h10, 16'h0);
    a0 = 0; a1 = 0; first_p = -1; last_cyc = -1; gap_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (m0_ack || m1_ack) begin
        if (first_p < 0) first_p = m1_ack ? 1 : 0;
        if (last_cyc >= 0 && c - last_cyc != 3) gap_bad++;
        last_cyc = c;
      end
      if (m0_ack) a0++;
      if (m1_ack) a1++;
    end
    drop_req(0); drop_req(1);
`ifdef DATA_MEM_ARB_RR_EN
    check_eq("tie_first_port", first_p, 0);
    check_eq("tie_acks_p0", a0, 2);
    check_eq("tie_acks_p1", a1, 2);
`else
    check_eq("tie_first_port", first_p, 1);
    check_eq("tie_acks_p0", a0, 0);
    check_eq("tie_acks_p1", a1, 4);
`endif
    check_eq("tie_ack_spacing", gap_bad, 0);
    tick();

    // Port 0 write.
    drive_req(0, 1, 8'h44, 16'hA5C3);
    tick();
    check_eq("p0wr_write_en", mem_write_en, 1'b1);
    check_eq("p0wr_address", mem_address, 8'h44);
    check_eq("p0wr_wdata", mem_wdata, 16'hA5C3);
    tick();
    check_eq("p0wr_ack", m0_ack, 1'b1);
    drop_req(0);
    tick();

    // Blocked write at 0x4E, then an allowed write at 0x4C.
    drive_req(1, 1, 8'h4E, 16'h1234);
    tick();
    check_eq("blk_write_en", mem_write_en, 1'b0);
    tick();
    check_eq("blk_ack", m1_ack, 1'b1);
    check_eq("blk_fault", m1_fault, 1'b1);
    drop_req(1);
    tick();
    drive_req(1, 1, 8'h4C, 16'h5678);
    tick();
    check_eq("ok_write_en", mem_write_en, 1'b1);
    tick();
    check_eq("ok_ack", m1_ack, 1'b1);
    check_eq("ok_fault", m1_fault, 1'b0);
    drop_req(1);
    tick();

    // debug_mode holds off port 0.
    debug_mode = 1;
    drive_req(0, 0, 8'h20, 16'h0);
    a0 = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (m0_ack) a0++;
    end
    check_eq("dbg_no_ack", a0, 0);
    debug_mode = 0;
    wait_ack(0, 10, n);
    check_eq("dbg_release_latency", n, 2);
    drop_req(0);
    tick();

    // Reset during ACCESS, then the held request retries.
    drive_req(1, 0, 8'h30, 16'h0);
    tick();
    check_eq("mid_read_en_before", mem_read_en, 1'b1);
    RST_N = 1'b0;
    model_reset();
    #1;
    check_eq("mid_read_en_async", mem_read_en, 1'b0);
    check_eq("mid_no_ack", m1_ack, 1'b0);
    @(negedge CLK);
    tick();
    RST_N = 1'b1;
    wait_ack(1, 10, n);
    check_eq("mid_retry_latency", n, 2);
    drop_req(1);
    tick();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (m0_ack) drop_req(0);
      if (m1_ack) drop_req(1);
      if (!m0_req && $urandom_range(0, 2) == 0)
        drive_req(0, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      if (!m1_req && $urandom_range(0, 2) == 0)
        drive_req(1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
      if ($urandom_range(0, 19) == 0) debug_mode = ~debug_mode;
    end
    drop_req(0); drop_req(1); debug_mode = 0;
    for (int c = 0; c < 4; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the single-port 256-byte data memory. The CPU load/store unit (port 0) and the debug/loader port (port 1) share the memory's single read/write interface. The block runs a request/acknowledge handshake with each requester, serialises accesses through a three-state FSM and blocks writes to the read-only I/O window. It sits between the core and the data memory, and its memory-side outputs drive the memory's address, enable and write-data inputs directly.

## Interface
Parameters:
- RO_LO, 8'h4D: lowest start address whose 2-byte write touches the read-only I/O window.
- RO_HI, 8'h51: highest start address whose 2-byte write touches the read-only I/O window.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- m0_req, m1_req  input  1  request; held high until the matching ack.
- m0_we, m1_we  input  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  input  8  byte address; stable while req is high.
- m0_wdata, m1_wdata  input  16  write data; stable while req is high.
- m0_ack, m1_ack  output  1  one-cycle pulse; the transaction is complete.
- m0_rdata, m1_rdata  output  16  read data; valid from the ack cycle, held until that port's next read.
- m0_fault, m1_fault  output  1  pulses with ack when a write was blocked.
- debug_mode  input  1  when high, port 0 requests are not granted.
- mem_address  output  8  memory address.
- mem_read_en, mem_write_en  output  1  memory enables; mutually exclusive.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  combinational memory read data.

## Operation
- Reset value of every output is 0. On reset the FSM enters IDLE and last_grant = 1, so port 0 wins the first tie.
- FSM states:
  - **IDLE**: sample the requests and select a winner. If any eligible request exists, register grant, address, data and enable, then go to ACCESS. Otherwise stay in IDLE.
  - **ACCESS**: exactly one cycle. mem_address, mem_wdata and one enable are asserted. At the end of the cycle, mem_rdata is captured into the winner's rdata if the access is a read. Go to DONE.
  - **DONE**: pulse ack for the winner, and fault if the write was blocked. All mem enables are low. Go to IDLE.
- Eligibility: m1_req is always eligible. m0_req is eligible only when debug_mode is 0. debug_mode rising mid-transaction does not abort the granted access.
- Arbitration (see Configuration): the grant is fixed for the whole transaction.
- Write blocking: a write is blocked when RO_LO ≤ addr ≤ RO_HI. A blocked write still runs ACCESS with both enables low, and DONE pulses ack and fault. Reads are never blocked.
- Address arithmetic: 8-bit. A 2-byte access at 8'hFF touches 8'hFF and 8'h00. The arbiter does not check alignment.
- Handshake: after ack, the requester must drop req or present a new request. A req still high in the following IDLE cycle is treated as a new transaction.
- Requests that change while not granted are sampled fresh in IDLE. There is no queuing.

## Timing
- Latency: req high in the IDLE cycle at edge N gives ACCESS in cycle N+1 and an ack pulse in cycle N+2.
- Peak throughput is one access per 3 cycles. With both ports continuously requesting, each port gets one access per 6 cycles under round-robin.
- rdata updates on the edge entering DONE and is stable during the ack cycle.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously). No ack is issued and the FSM resumes in IDLE.

## Configuration
- Macro DATA_MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the port not granted last wins, and last_grant updates on each grant.
- Undefined: fixed priority, with port 1 (debug) always winning a tie. last_grant is not implemented and is tied to 1.

## Test plan
- **Reset**: hold RST_N low for 3 cycles, then release. All outputs are 0, and the first tie goes to port 0 (RR) or port 1 (fixed).
- **Port 0 write**: addr 8'h44, wdata 16'hA5C3. Check mem_write_en=1, mem_address=8'h44, mem_wdata=16'hA5C3 in cycle N+1, then m0_ack in cycle N+2.
- **Tie with RR defined**: both ports request reads of 8'h40 and 8'h10 back-to-back for 12 cycles. Grants alternate 0,1,0,1 with acks spaced 3 cycles apart, and each port receives its mem_rdata.
- **Blocked write**: port 1 writes 8'h4E. mem_write_en stays 0 throughout, and m1_ack and m1_fault pulse together. A write to 8'h4C completes with fault=0.
- **debug_mode**: debug_mode=1 with m0_req held high and no m1_req. No m0_ack for 10 cycles. Dropping debug_mode gives m0_ack 2 cycles after the next IDLE.
- **Reset mid-access**: assert RST_N low during ACCESS. mem_read_en falls immediately, no ack is issued, and a retried request completes normally.
